seq_div_50x24: RTL and testbench

- Sequential radix-2 restoring divider; inverse of the 26x24 mantissa multiplier.
- Takes a 50-bit dividend (a product-width value) and a 24-bit divisor; returns the 26-bit quotient and 24-bit remainder.
- Used on the mantissa divide / de-quantisation path.
- Computes one quotient bit per cycle behind valid/ready handshakes on both sides.

---
 rtl/seq_div_50x24_pkg.sv | 15 +
 rtl/seq_div_50x24_div_step.sv | 22 ++
 rtl/seq_div_50x24.sv | 128 ++++++++++++
 tb/tb_seq_div_50x24.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/seq_div_50x24_pkg.sv
// Width constants and divider state encoding shared by the mantissa
// multiply and divide datapaths.
package quant_arith_pkg;

  localparam int unsigned A_W = 26;
  localparam int unsigned B_W = 24;
  localparam int unsigned Z_W = A_W + B_W;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } div_state_t;

endpackage

// File: rtl/seq_div_50x24_div_step.sv
// One restoring-division step: shift in the next dividend bit and subtract
// the divisor when the partial remainder allows it.
module div_step #(
  parameter int unsigned W = quant_arith_pkg::B_W
) (
  input  logic [W-1:0] r,
  input  logic         din,
  input  logic [W-1:0] b,
  output logic [W-1:0] r_next,
  output logic         qbit
);

  logic [W:0] t;

  // r < b on entry, so t < 2b and the restored or reduced value fits W bits.
  always_comb begin
    t      = {r, din};
    qbit   = (t >= {1'b0, b});
    r_next = W'(qbit ? (t - {1'b0, b}) : t);
  end

endmodule

// File: rtl/seq_div_50x24.sv
// Sequential radix-2 restoring divider, 50-bit dividend by 24-bit divisor,
// one quotient bit per cycle behind valid/ready handshakes.
module seq_div_50x24 #(
  parameter  int unsigned A_W = quant_arith_pkg::A_W,
  parameter  int unsigned B_W = quant_arith_pkg::B_W,
  localparam int unsigned Z_W = A_W + B_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [Z_W-1:0] z,
  input  logic [B_W-1:0] b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [A_W-1:0] q,
  output logic [B_W-1:0] r,
  output logic           dbz,
  output logic           ovf
);

  import quant_arith_pkg::*;

  localparam int unsigned C_W = $clog2(A_W);

  div_state_t     state_q, state_d;
  logic [C_W-1:0] cnt_q, cnt_d;
  logic [B_W-1:0] rem_q, rem_d;
  logic [A_W-1:0] dsr_q, dsr_d;
  logic [B_W-1:0] bq_q, bq_d;
  logic [A_W-1:0] q_q, q_d;
  logic           dbz_q, dbz_d;
  logic           ovf_q, ovf_d;
  logic [B_W-1:0] step_r;
  logic           step_q;

  div_step #(.W(B_W)) u_step (
    .r      (rem_q),
    .din    (dsr_q[A_W-1]),
    .b      (bq_q),
    .r_next (step_r),
    .qbit   (step_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      dsr_q   <= '0;
      bq_q    <= '0;
      q_q     <= '0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dsr_q   <= dsr_d;
      bq_q    <= bq_d;
      q_q     <= q_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    dsr_d   = dsr_q;
    bq_d    = bq_q;
    q_d     = q_q;
    dbz_d   = dbz_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          bq_d  = b;
          rem_d = z[Z_W-1:A_W];
          dsr_d = z[A_W-1:0];
          q_d   = '0;
          dbz_d = 1'b0;
          ovf_d = 1'b0;
          // Divide-by-zero and quotient overflow finish without iterating.
          if (b == '0) begin
            state_d = DONE;
            q_d     = '1;
            rem_d   = z[B_W-1:0];
            dbz_d   = 1'b1;
          end else if (z[Z_W-1:A_W] >= b) begin
            state_d = DONE;
            q_d     = '1;
            rem_d   = '0;
            ovf_d   = 1'b1;
          end else begin
            state_d = CALC;
            cnt_d   = C_W'(A_W - 1);
          end
        end
      end
      CALC: begin
        rem_d = step_r;
        q_d   = {q_q[A_W-2:0], step_q};
        dsr_d = dsr_q << 1;
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign q         = q_q;
  assign r         = rem_q;
  assign dbz       = dbz_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_seq_div_50x24.sv
// Self-checking bench for seq_div_50x24: directed cases plus a random sweep
// against an arithmetic reference model.
module tb_seq_div_50x24;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [49:0] z;
  logic [23:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [25:0] q;
  logic [23:0] r;
  logic        dbz;
  logic        ovf;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  seq_div_50x24 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .z         (z),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .q         (q),
    .r         (r),
    .dbz       (dbz),
    .ovf       (ovf)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference: plain integer division with the special cases resolved first.
  function automatic void model(input logic [49:0] zz, input logic [23:0] bb,
                                output logic [25:0] eq, output logic [23:0] er,
                                output logic edbz, output logic eovf, output int elat);
    longint unsigned zl, bl;
    zl = 64'(zz);
    bl = 64'(bb);
    edbz = 1'b0;
    eovf = 1'b0;
    if (bl == 0) begin
      eq = '1; er = zz[23:0]; edbz = 1'b1; elat = 0;
    end else if ((zl >> 26) >= bl) begin
      eq = '1; er = '0; eovf = 1'b1; elat = 0;
    end else begin
      eq = 26'(zl / bl); er = 24'(zl % bl); elat = 26;
    end
  endfunction

  task automatic do_op(input logic [49:0] zz, input logic [23:0] bb, input int hold, input bit poke);
    logic [25:0] eq, q0;
    logic [23:0] er, r0;
    logic        edbz, eovf;
    int          elat, lat;
    longint unsigned recon;
    model(zz, bb, eq, er, edbz, eovf, elat);
    @(negedge clk);
    z = zz; b = bb; in_valid = 1'b1;
    chk("in_ready_idle", 64'(in_ready), 64'(1));
    @(posedge clk); #1;
    in_valid = poke;
    z = 50'({$urandom, $urandom});
    b = 24'($urandom);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 3) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    chk("latency", 64'(lat), 64'(elat));
    chk("q", 64'(q), 64'(eq));
    chk("r", 64'(r), 64'(er));
    chk("dbz", 64'(dbz), 64'(edbz));
    chk("ovf", 64'(ovf), 64'(eovf));
    chk("in_ready_done", 64'(in_ready), 64'(0));
    if (!edbz && !eovf) begin
      recon = 64'(q) * 64'(bb) + 64'(r);
      chk("identity", recon, 64'(zz));
      chk("r_lt_b", 64'(r < bb), 64'(1));
    end
    q0 = eq;
    r0 = er;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk("hold_valid", 64'(out_valid), 64'(1));
      chk("hold_q", 64'(q), 64'(q0));
      chk("hold_r", 64'(r), 64'(r0));
      chk("hold_in_ready", 64'(in_ready), 64'(0));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("handoff_valid", 64'(out_valid), 64'(0));
    chk("handoff_in_ready", 64'(in_ready), 64'(1));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; z = '0; b = '0;
    #2;
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_q", 64'(q), 64'(0));
    chk("rst_r", 64'(r), 64'(0));
    chk("rst_flags", 64'({dbz, ovf}), 64'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // out_ready with nothing pending must not disturb the idle state.
    @(negedge clk); out_ready = 1'b1;
    @(negedge clk); out_ready = 1'b0;
    chk("idle_out_ready", 64'({in_ready, out_valid}), 64'(2'b10));

    do_op(50'd3000, 24'd1000, 0, 1'b0);
    do_op(50'(64'h3FFFFFF * 64'hFFFFFF), 24'hFFFFFF, 0, 1'b1);
    do_op(50'd12345679, 24'd1000, 5, 1'b0);
    do_op(50'h1234, 24'h0, 2, 1'b1);
    do_op(50'h3FFFFFFFFFFFF, 24'h1, 0, 1'b1);
    do_op(50'(64'd1000 << 26), 24'd1000, 0, 1'b0);
    do_op(50'((64'd1000 << 26) - 1), 24'd1000, 0, 1'b0);
    do_op(50'h3FFFFFF, 24'h1, 0, 1'b0);
    do_op(50'h0, 24'h5, 0, 1'b0);

    // Reset in the middle of CALC discards the partial result.
    @(negedge clk); z = 50'd3000; b = 24'd1000; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1; rst = 1'b1; #1;
    chk("midrst_in_ready", 64'(in_ready), 64'(1));
    chk("midrst_out_valid", 64'(out_valid), 64'(0));
    chk("midrst_q", 64'(q), 64'(0));
    chk("midrst_r", 64'(r), 64'(0));
    chk("midrst_flags", 64'({dbz, ovf}), 64'(0));
    @(negedge clk); @(negedge clk); rst = 1'b0;
    do_op(50'd100, 24'd7, 0, 1'b0);

    for (int i = 0; i < 2500; i++) begin
      logic [23:0] rb;
      logic [49:0] rz;
      longint unsigned lim;
      rb = 24'($urandom) >> $urandom_range(23, 0);
      if (rb == '0) rb = 24'd1;
      lim = 64'(rb) << 26;
      rz = 50'({$urandom, $urandom} % lim);
      do_op(rz, rb, 0, ($urandom_range(1, 0) == 1));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
